weight_loader: RTL and testbench
================================

WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 SHALL have parameter FIXED_BITS, default 8, integer bits of the Q-format word.
REQ-002 SHALL have parameter FRACTIONAL_BITS, default 8, fractional bits of the Q-format word; W = FIXED_BITS+FRACTIONAL_BITS.
REQ-003 SHALL have parameter NUM_OUTPUTS, default 4, number of neuron connections to load (>=1); IW = max(1, clog2(NUM_OUTPUTS+1)).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  begin a load sequence (sampled in IDLE only).
REQ-007 abort  input  1  cancel an in-progress load.
REQ-008 in_valid  input  1  upstream weight word valid.
REQ-009 in_ready  output  1  loader can accept a weight word.
REQ-010 in_data  input  W  signed Q-format weight word.
REQ-011 set_weight_en  output  NUM_OUTPUTS  one-hot write strobe toward the neuron stage.
REQ-012 set_weight_val  output  NUM_OUTPUTS*W  flat bus; slice k = bits [k*W +: W] carries the value for connection k.
REQ-013 busy  output  1  high in LOAD and DONE.
REQ-014 done  output  1  one-cycle pulse on completion.
REQ-015 load_index  output  IW  number of words accepted in the current sequence.
REQ-016 checksum  output  W  mod-2^W sum of words accepted in the current sequence.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-018 IDLE: in_ready=0; start=1 -> LOAD next cycle, load_index<=0, checksum<=0.
REQ-019 LOAD: in_ready=1 combinationally while state is LOAD and abort=0.
REQ-020 Handshake: word accepted on a rising edge where in_valid=1 and in_ready=1; in_data ignored otherwise.
REQ-021 On acceptance at edge N with load_index=k: during cycle N+1 set_weight_en is one-hot bit k, slice k of set_weight_val = accepted word, and all other slices = 0.
REQ-022 set_weight_en SHALL be all-zero in every cycle not following an acceptance; set_weight_val slices SHALL be 0 whenever set_weight_en is 0.
REQ-023 On acceptance: load_index <= k+1; checksum <= checksum + in_data, wrapping mod 2^W, no saturation.
REQ-024 Acceptance of word NUM_OUTPUTS-1 -> DONE next cycle; the last strobe and done=1 occur in the same cycle.
REQ-025 DONE: lasts exactly one cycle, in_ready=0, done=1, then IDLE; load_index and checksum hold until the next start.
REQ-026 abort=1 in LOAD -> IDLE next cycle; abort SHALL win over a same-cycle handshake (word not accepted, no strobe); done not pulsed; load_index/checksum hold the partial values.
REQ-027 abort SHALL be ignored in IDLE and DONE; start SHALL be ignored in LOAD and DONE.
REQ-028 in_valid gaps SHALL stall LOAD indefinitely without timeout.
REQ-029 All outputs except in_ready SHALL be registered.

Reset
REQ-030 rst_n=0 at a rising edge SHALL, regardless of state, force IDLE, set_weight_en=0, set_weight_val=0, done=0, busy=0, load_index=0, checksum=0.
REQ-031 Reset asserted mid-LOAD SHALL cancel the sequence; no strobe SHALL occur in the cycle after the reset edge.
REQ-032 With rst_n=0, in_ready SHALL be 0.

Verification
REQ-033 NUM_OUTPUTS=4; start, then words 0x0100,0x0080,0xFF00,0x0040 on back-to-back valid -> strobes 0001,0010,0100,1000 on consecutive cycles, done with the 1000 strobe, checksum 0x00C0, load_index 4.
REQ-034 Same words with in_valid low for 3 cycles between each word -> identical strobe order and values, no strobe in gap cycles, done only after the 4th word.
REQ-035 Abort asserted with in_valid=1 on the 3rd word -> only strobes 0001,0010 occur, no done, load_index 2, state IDLE; a new start then restarts from index 0 with checksum 0.
REQ-036 rst_n=0 for one cycle after the 2nd accepted word -> next-cycle outputs all zero, IDLE; start pulses while busy are ignored (no index reset).
REQ-037 Words 0x7FFF,0x0002 (NUM_OUTPUTS=2) -> checksum wraps to 0x8001; done pulses exactly one cycle, then in_ready=0.

Source files
------------

// File: rtl/weight_loader.sv
// Streams NUM_OUTPUTS signed Q-format weights into a neuron stage, one
// registered one-hot write strobe per accepted word, with a running checksum.
module weight_loader #(
    parameter int FIXED_BITS      = 8,
    parameter int FRACTIONAL_BITS = 8,
    parameter int NUM_OUTPUTS     = 4,
    localparam int W  = FIXED_BITS + FRACTIONAL_BITS,
    localparam int IW = ($clog2(NUM_OUTPUTS + 1) < 1) ? 1 : $clog2(NUM_OUTPUTS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_data,
    output logic [NUM_OUTPUTS-1:0]   set_weight_en,
    output logic [NUM_OUTPUTS*W-1:0] set_weight_val,
    output logic                     busy,
    output logic                     done,
    output logic [IW-1:0]            load_index,
    output logic [W-1:0]             checksum,
    output logic [1:0]               fsm_state
);

    // Handshake: a word transfers on a rising clk edge where in_valid and
    // in_ready are both 1; in_ready is high only in LOAD without abort.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   accept;
    logic   last_word;

    assign fsm_state = state;
    assign last_word = (load_index == IW'(NUM_OUTPUTS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (accept && last_word) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = rst_n && (state == LOAD) && !abort;
        accept   = in_valid && in_ready;
        busy     = (state != IDLE);
        done     = (state == DONE);
    end

    // Strobe and value are cleared every cycle so they only appear for one
    // cycle after an acceptance, with every unselected slice at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            set_weight_en  <= '0;
            set_weight_val <= '0;
            load_index     <= '0;
            checksum       <= '0;
        end else begin
            set_weight_en  <= '0;
            set_weight_val <= '0;
            if (state == IDLE && start) begin
                load_index <= '0;
                checksum   <= '0;
            end
            if (accept) begin
                for (int k = 0; k < NUM_OUTPUTS; k++) begin
                    if (load_index == IW'(k)) begin
                        set_weight_en[k]         <= 1'b1;
                        set_weight_val[k*W +: W] <= in_data;
                    end
                end
                load_index <= load_index + 1'b1;
                checksum   <= checksum + in_data;
            end
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: a 4-connection instance checked through a
// strobe scoreboard plus a 2-connection instance for checksum wrap.
module tb_weight_loader;

    logic        clk;
    logic        rst_n;
    logic        start, abort, in_valid;
    logic [15:0] in_data;
    logic        in_ready, busy, done;
    logic [3:0]  en4;
    logic [63:0] val4;
    logic [2:0]  idx4;
    logic [15:0] cks4;
    logic [1:0]  st4;

    logic        start2, abort2, in_valid2;
    logic [15:0] in_data2;
    logic        in_ready2, busy2, done2;
    logic [1:0]  en2;
    logic [31:0] val2;
    logic [1:0]  idx2;
    logic [15:0] cks2;
    logic [1:0]  st2;

    int          tests = 0;
    int          fails = 0;
    int          idx   = 0;
    logic        mon_en = 1'b0;
    logic [67:0] exp_q[$];
    logic [67:0] mon_exp;

    weight_loader #(.FIXED_BITS(8), .FRACTIONAL_BITS(8), .NUM_OUTPUTS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .set_weight_en(en4), .set_weight_val(val4), .busy(busy), .done(done),
        .load_index(idx4), .checksum(cks4), .fsm_state(st4)
    );

    weight_loader #(.FIXED_BITS(8), .FRACTIONAL_BITS(8), .NUM_OUTPUTS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .set_weight_en(en2), .set_weight_val(val2), .busy(busy2), .done(done2),
        .load_index(idx2), .checksum(cks2), .fsm_state(st2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        idx   = 0;
    endtask

    // Drives one word that the bench knows will be accepted and records the
    // strobe it must produce one cycle later.
    task automatic send_word(input logic [15:0] data, input int gap);
        logic [3:0]  e_en;
        logic [63:0] e_val;
        e_en  = 4'b0001 << idx;
        e_val = {48'd0, data} << (idx * 16);
        exp_q.push_back({e_en, e_val});
        idx++;
        in_valid = 1'b1;
        in_data  = data;
        tick();
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        repeat (gap) tick();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (en4 !== 4'd0) begin
                if (exp_q.size() == 0) begin
                    check("unexp_strobe", 68'(en4), 68'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("strobe", {en4, val4}, mon_exp);
                end
            end else begin
                check("val_zero_no_strobe", 68'(val4), 68'd0);
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 16'h0;
        start2 = 1'b0; abort2 = 1'b0; in_valid2 = 1'b0; in_data2 = 16'h0;

        // Reset state
        repeat (2) tick();
        check("rst_in_ready", 68'(in_ready), 68'd0);
        check("rst_en", 68'(en4), 68'd0);
        check("rst_val", 68'(val4), 68'd0);
        check("rst_busy", 68'(busy), 68'd0);
        check("rst_done", 68'(done), 68'd0);
        check("rst_index", 68'(idx4), 68'd0);
        check("rst_checksum", 68'(cks4), 68'd0);
        check("rst_state", 68'(st4), 68'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();
        check("idle_in_ready", 68'(in_ready), 68'd0);

        // Back-to-back load of four words
        do_start();
        check("load_busy", 68'(busy), 68'd1);
        check("load_in_ready", 68'(in_ready), 68'd1);
        send_word(16'h0100, 0);
        send_word(16'h0080, 0);
        send_word(16'hFF00, 0);
        check("b2b_no_early_done", 68'(done), 68'd0);
        send_word(16'h0040, 0);
        check("b2b_done", 68'(done), 68'd1);
        check("b2b_done_in_ready", 68'(in_ready), 68'd0);
        check("b2b_index", 68'(idx4), 68'd4);
        check("b2b_checksum", 68'(cks4), 68'h00C0);
        tick();
        check("b2b_done_one_cycle", 68'(done), 68'd0);
        check("b2b_idle_busy", 68'(busy), 68'd0);
        check("b2b_hold_checksum", 68'(cks4), 68'h00C0);
        check("b2b_hold_index", 68'(idx4), 68'd4);

        // Same words with three idle cycles between them
        do_start();
        check("gap_index_cleared", 68'(idx4), 68'd0);
        send_word(16'h0100, 3);
        send_word(16'h0080, 3);
        send_word(16'hFF00, 3);
        check("gap_no_early_done", 68'(done), 68'd0);
        check("gap_still_load", 68'(st4), 68'd1);
        send_word(16'h0040, 0);
        check("gap_done", 68'(done), 68'd1);
        check("gap_checksum", 68'(cks4), 68'h00C0);
        tick();

        // Abort on the third word while it is offered
        do_start();
        send_word(16'h0100, 0);
        send_word(16'h0080, 0);
        in_valid = 1'b1; in_data = 16'hFF00; abort = 1'b1;
        #1;
        check("abort_in_ready", 68'(in_ready), 68'd0);
        tick();
        in_valid = 1'b0; abort = 1'b0;
        check("abort_state_idle", 68'(st4), 68'd0);
        check("abort_no_done", 68'(done), 68'd0);
        check("abort_index", 68'(idx4), 68'd2);
        check("abort_checksum", 68'(cks4), 68'h0180);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle_ignored", 68'(idx4), 68'd2);
        do_start();
        check("restart_index", 68'(idx4), 68'd0);
        check("restart_checksum", 68'(cks4), 68'd0);
        send_word(16'h0001, 0);
        send_word(16'h0002, 0);
        send_word(16'h0003, 0);
        send_word(16'h0004, 0);
        check("restart_done", 68'(done), 68'd1);
        check("restart_sum", 68'(cks4), 68'h000A);
        tick();

        // Reset one cycle after the second accepted word
        do_start();
        send_word(16'h1111, 0);
        send_word(16'h2222, 0);
        rst_n = 1'b0; in_valid = 1'b1; in_data = 16'h3333;
        #1;
        check("rst_mid_in_ready", 68'(in_ready), 68'd0);
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        check("rst_mid_en", 68'(en4), 68'd0);
        check("rst_mid_val", 68'(val4), 68'd0);
        check("rst_mid_state", 68'(st4), 68'd0);
        check("rst_mid_busy", 68'(busy), 68'd0);
        check("rst_mid_index", 68'(idx4), 68'd0);
        check("rst_mid_checksum", 68'(cks4), 68'd0);

        // Start pulses while busy are ignored
        do_start();
        send_word(16'h0010, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_load_ignored", 68'(idx4), 68'd1);
        send_word(16'h0020, 0);
        send_word(16'h0030, 0);
        send_word(16'h0040, 0);
        check("start_done", 68'(done), 68'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_done_state", 68'(st4), 68'd0);
        check("start_in_done_index", 68'(idx4), 68'd4);
        check("start_in_done_checksum", 68'(cks4), 68'h00A0);

        // Two-connection instance: checksum wraps, done lasts one cycle
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        in_valid2 = 1'b1; in_data2 = 16'h7FFF;
        tick();
        in_data2 = 16'h0002;
        check("n2_strobe0_en", 68'(en2), 68'b01);
        check("n2_strobe0_val", 68'(val2), 68'h0000_7FFF);
        tick();
        in_valid2 = 1'b0;
        check("n2_strobe1_en", 68'(en2), 68'b10);
        check("n2_strobe1_val", 68'(val2), 68'h0002_0000);
        check("n2_done", 68'(done2), 68'd1);
        check("n2_checksum_wrap", 68'(cks2), 68'h8001);
        check("n2_index", 68'(idx2), 68'd2);
        tick();
        check("n2_done_one_cycle", 68'(done2), 68'd0);
        check("n2_in_ready_after", 68'(in_ready2), 68'd0);
        check("n2_no_strobe_after", 68'(en2), 68'd0);
        check("n2_hold_checksum", 68'(cks2), 68'h8001);

        repeat (3) tick();
        check("queue_drained", 68'(exp_q.size()), 68'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
